// File: rtl/press_classifier.sv
// press_classifier: classifies debounced switch gestures as short, long or double presses.
//
// Parameters:
//   LONG_CYCLES - hold time in clk cycles that qualifies a long press (>= 2)
//   GAP_CYCLES  - max release-to-press gap in clk cycles for a double press (>= 2)
//
// Ports:
//   clk_i       - clock, all logic on the rising edge
//   rst_i       - synchronous active-low reset
//   db_level_i  - debounced switch level
//   db_tick_i   - one-cycle pulse on the debounced rising edge
//   short_o     - one-cycle pulse, short press classified
//   long_o      - one-cycle pulse, long press classified
//   double_o    - one-cycle pulse, double press classified
//   event_cnt_o - wrap-around count of classified gestures
module press_classifier #(
    parameter int unsigned LONG_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 12_500_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       db_level_i,
    input  logic       db_tick_i,
    output logic       short_o,
    output logic       long_o,
    output logic       double_o,
    output logic [7:0] event_cnt_o
);

    localparam int unsigned MaxCycles = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int unsigned TimerW    = $clog2(MaxCycles + 1);

    localparam logic [TimerW-1:0] LongLimit = TimerW'(LONG_CYCLES - 1);
    localparam logic [TimerW-1:0] GapLimit  = TimerW'(GAP_CYCLES - 1);
    localparam logic [TimerW-1:0] TimerOne  = TimerW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StPress1,
        StWait2,
        StPress2,
        StLongHold
    } state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              short_q, short_d;
    logic              long_q, long_d;
    logic              double_q, double_d;
    logic [7:0]        cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (db_tick_i) begin
                    state_d = StPress1;
                end
            end
            StPress1: begin
                // Release is checked first so it wins a tie with the long limit.
                if (!db_level_i) begin
                    state_d = StWait2;
                end else if (timer_q == LongLimit) begin
                    long_d  = 1'b1;
                    state_d = StLongHold;
                end else begin
                    timer_d = timer_q + TimerOne;
                end
            end
            StWait2: begin
                // A second tick wins a tie with the gap limit.
                if (db_tick_i) begin
                    state_d = StPress2;
                end else if (timer_q == GapLimit) begin
                    short_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TimerOne;
                end
            end
            StPress2: begin
                if (!db_level_i) begin
                    double_d = 1'b1;
                    state_d  = StIdle;
                end
            end
            StLongHold: begin
                if (!db_level_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end

        if (short_d || long_d || double_d) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            cnt_q    <= cnt_d;
        end
    end

    assign short_o     = short_q;
    assign long_o      = long_q;
    assign double_o    = double_q;
    assign event_cnt_o = cnt_q;

endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: self-checking bench for press_classifier with a timestamp-based gesture
// model, per-cycle output comparison, directed boundary scenarios and randomized gestures.
module tb_press_classifier;

    localparam int LONG = 20;
    localparam int GAP  = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lvl = 1'b0;
    logic       tk = 1'b0;
    logic       short_o, long_o, double_o;
    logic [7:0] event_cnt_o;

    press_classifier #(
        .LONG_CYCLES(LONG),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .db_level_i (lvl),
        .db_tick_i  (tk),
        .short_o    (short_o),
        .long_o     (long_o),
        .double_o   (double_o),
        .event_cnt_o(event_cnt_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    int edge_n = 0;
    bit check_en = 1'b0;

    // Gesture model: 0 idle, 1 first press held, 2 waiting for second press,
    // 3 long press held, 4 second press held. Times are edge indices.
    int   m_mode = 0;
    int   m_t0   = 0;
    int   m_cnt  = 0;
    logic e_s = 1'b0, e_l = 1'b0, e_d = 1'b0;

    int d_short = 0, d_long = 0, d_double = 0;
    int last_short = -1, last_long = -1, last_double = -1;

    task automatic chk(input string name, input int act, input int expv);
        n_tot++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    task automatic model(input logic l, input logic t, input logic r, input int n);
        e_s = 1'b0;
        e_l = 1'b0;
        e_d = 1'b0;
        if (!r) begin
            m_mode = 0;
            m_cnt  = 0;
            return;
        end
        case (m_mode)
            0: if (t) begin m_mode = 1; m_t0 = n; end
            1: begin
                if (!l) begin
                    m_mode = 2;
                    m_t0   = n;
                end else if (n - m_t0 == LONG) begin
                    e_l    = 1'b1;
                    m_mode = 3;
                end
            end
            2: begin
                if (t) m_mode = 4;
                else if (n - m_t0 == GAP) begin
                    e_s    = 1'b1;
                    m_mode = 0;
                end
            end
            3: if (!l) m_mode = 0;
            4: if (!l) begin e_d = 1'b1; m_mode = 0; end
            default: m_mode = 0;
        endcase
        if (e_s || e_l || e_d) m_cnt = (m_cnt + 1) % 256;
    endtask

    // Drive the inputs for the next rising edge and advance the model to it.
    task automatic step(input logic l, input logic t, input logic r = 1'b1);
        @(negedge clk);
        #1;
        lvl   = l;
        tk    = t;
        rst_n = r;
        edge_n++;
        model(l, t, r, edge_n);
        if (!r) check_en = 1'b1;
    endtask

    // Only valid right after step(): waits until the DUT reflects the last driven edge.
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int h, output int k);
        step(1'b1, 1'b1);
        k = edge_n;
        repeat (h - 1) step(1'b1, 1'b0);
    endtask

    task automatic idle(input int c);
        repeat (c) step(1'b0, 1'b0);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    logic [10:0] got_v, exp_v;
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                got_v = {short_o, long_o, double_o, event_cnt_o};
                exp_v = {e_s, e_l, e_d, 8'(m_cnt)};
                n_tot++;
                if (got_v === exp_v) n_pass++;
                else $display("FAIL cycle_outputs edge %0d: got s/l/d/cnt=%b/%b/%b/%0d, expected %b/%b/%b/%0d",
                              edge_n, short_o, long_o, double_o, event_cnt_o,
                              e_s, e_l, e_d, m_cnt);
                if (short_o === 1'b1) begin d_short++; last_short = edge_n; end
                if (long_o === 1'b1) begin d_long++; last_long = edge_n; end
                if (double_o === 1'b1) begin d_double++; last_double = edge_n; end
            end
        end
    end

    int k, k2, r, r2, s0, l0, x0;

    task automatic mark();
        s0 = d_short;
        l0 = d_long;
        x0 = d_double;
    endtask

    initial begin
        // Reset state
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        sync();
        chk("reset_short", int'(short_o), 0);
        chk("reset_long", int'(long_o), 0);
        chk("reset_double", int'(double_o), 0);
        chk("reset_cnt", int'(event_cnt_o), 0);

        // Short press
        mark();
        press(5, k);
        step(1'b0, 1'b0);
        r = edge_n;
        idle(15);
        sync();
        chk("short_pulses", d_short - s0, 1);
        chk("short_delay", last_short - r, 10);
        chk("short_no_long", d_long - l0, 0);
        chk("short_no_double", d_double - x0, 0);
        chk("short_cnt", int'(event_cnt_o), 1);

        // Long press
        step(1'b0, 1'b0, 1'b0);
        mark();
        press(30, k);
        step(1'b0, 1'b0);
        idle(15);
        sync();
        chk("long_pulses", d_long - l0, 1);
        chk("long_delay", last_long - k, 20);
        chk("long_no_short", d_short - s0, 0);
        chk("long_cnt", int'(event_cnt_o), 1);

        // Double press
        step(1'b0, 1'b0, 1'b0);
        mark();
        press(4, k);
        idle(4);
        press(3, k2);
        step(1'b0, 1'b0);
        r2 = edge_n;
        idle(15);
        sync();
        chk("double_pulses", d_double - x0, 1);
        chk("double_delay", last_double - r2, 0);
        chk("double_no_short", d_short - s0, 0);
        chk("double_cnt", int'(event_cnt_o), 1);

        // Release exactly on the long-limit edge
        step(1'b0, 1'b0, 1'b0);
        mark();
        press(LONG, k);
        step(1'b0, 1'b0);
        r = edge_n;
        idle(15);
        sync();
        chk("tie_release_no_long", d_long - l0, 0);
        chk("tie_release_short", d_short - s0, 1);
        chk("tie_release_delay", last_short - r, 10);

        // Second tick exactly on the gap-limit edge
        step(1'b0, 1'b0, 1'b0);
        mark();
        press(4, k);
        step(1'b0, 1'b0);
        r = edge_n;
        idle(GAP - 1);
        press(2, k2);
        step(1'b0, 1'b0);
        idle(15);
        sync();
        chk("tie_gap_no_short", d_short - s0, 0);
        chk("tie_gap_double", d_double - x0, 1);

        // Reset mid-gesture
        step(1'b0, 1'b0, 1'b0);
        mark();
        step(1'b1, 1'b1);
        repeat (9) step(1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        sync();
        chk("midreset_cnt", int'(event_cnt_o), 0);
        chk("midreset_pulses", int'({short_o, long_o, double_o}), 0);
        repeat (5) step(1'b1, 1'b0);
        idle(30);
        sync();
        chk("midreset_no_pulse", (d_short - s0) + (d_long - l0) + (d_double - x0), 0);
        press(5, k);
        idle(13);
        sync();
        chk("midreset_fresh_short", d_short - s0, 1);
        chk("midreset_fresh_cnt", int'(event_cnt_o), 1);

        // Randomized gestures with glitch ticks and occasional resets
        for (int g = 0; g < 200; g++) begin
            int h, gap;
            h = $urandom_range(1, 30);
            step(1'b1, 1'b1);
            for (int i = 0; i < h - 1; i++) begin
                step(1'b1, ($urandom_range(0, 15) == 0));
            end
            gap = $urandom_range(1, 14);
            for (int i = 0; i < gap; i++) begin
                step(1'b0, 1'b0, ($urandom_range(0, 80) != 0));
            end
        end
        idle(40);

        // Counter wrap
        step(1'b0, 1'b0, 1'b0);
        for (int p = 1; p <= 256; p++) begin
            press(2, k);
            idle(11);
            if (p == 255) begin
                sync();
                chk("wrap_255", int'(event_cnt_o), 255);
            end
            if (p == 256) begin
                sync();
                chk("wrap_0", int'(event_cnt_o), 0);
            end
        end
        idle(3);
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
